// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the IRAM, and pairs the
// registered IRAM read data with the PC that produced it for decode.
//
// Handshake: if_valid qualifies if_pc/if_instr in the same cycle. While
// stall is high, decode is not taking the pair, so the pair is held
// stable. redirect is sampled on the clock edge and does not change
// if_valid in the cycle where it is raised. Decode must ignore the
// current pair whenever it raises redirect itself.
module fetch_unit #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_instr,
  output logic              halted,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;            // address being presented to IRAM
  logic [31:0] pc_d1_q, pc_d1_d;      // PC whose data is on imem_rdata
  logic        valid_d1_q, valid_d1_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        halted_q, halted_d;

  // State registers; clear is asynchronous and active-low.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      pc_d1_q      <= 32'h0;
      valid_d1_q   <= 1'b0;
      hold_instr_q <= 32'h0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_d1_q      <= pc_d1_d;
      valid_d1_q   <= valid_d1_d;
      hold_instr_q <= hold_instr_d;
      halted_q     <= halted_d;
    end
  end

  // Next-state logic: redirect outranks stall and normal advance.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_d1_d      = pc_d1_q;
    valid_d1_d   = valid_d1_q;
    hold_instr_d = hold_instr_q;
    halted_d     = halted_q;

    if ((state_q != ST_HALT) && redirect) begin
      if (redirect_pc[1:0] == 2'b00) begin
        // Kill the fetch in flight; the target shows up two edges later.
        pc_d       = redirect_pc;
        valid_d1_d = 1'b0;
        state_d    = ST_RUN;
      end else begin
        halted_d   = 1'b1;
        valid_d1_d = 1'b0;
        state_d    = ST_HALT;
      end
    end else begin
      case (state_q)
        ST_BOOT: begin
          // No valid output exists yet, so stall has nothing to hold.
          pc_d1_d    = pc_q;
          valid_d1_d = 1'b1;
          pc_d       = pc_q + 32'd4;
          state_d    = ST_RUN;
        end
        ST_RUN: begin
          if (!stall) begin
            pc_d1_d    = pc_q;
            valid_d1_d = 1'b1;
            pc_d       = pc_q + 32'd4;
          end else if (valid_d1_q) begin
            // Capture the instruction being held; IRAM keeps reading pc_q.
            hold_instr_d = imem_rdata;
            state_d      = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            // imem_rdata already carries the word at pc_q, nothing is lost.
            pc_d1_d    = pc_q;
            valid_d1_d = 1'b1;
            pc_d       = pc_q + 32'd4;
            state_d    = ST_RUN;
          end
        end
        default: begin
          // HALT: frozen until clear.
        end
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    imem_addr = pc_q[ADDR_W+1:2];
    if_pc     = pc_d1_q;
    halted    = halted_q;
    dbg_state = state_q;
    if_valid  = 1'b0;
    if_instr  = imem_rdata;
    case (state_q)
      ST_RUN:  if_valid = valid_d1_q;
      ST_HOLD: begin
        if_valid = 1'b1;
        if_instr = hold_instr_q;
      end
      default: if_valid = 1'b0;
    endcase
  end

endmodule
